// File: rtl/brq_idu_pkg.sv
// brq_idu_pkg: shared types for the Buraq decode-to-execute stage
package brq_idu_pkg;

   localparam int BRQ_XLEN = 32;

   typedef enum logic [1:0] {
      RUN,
      HZ_STALL,
      BP_STALL
   } idu_state_t;

   typedef struct packed {
      logic                hit;
      logic                hazard;
      logic [BRQ_XLEN-1:0] data;
   } src_res_t;

endpackage

// File: rtl/brq_idu_if.sv
// brq_idu_if: decode-side, forwarding, flush and EX-side signals of the ID/EX stage
interface brq_idu_if #(
   parameter int XLEN    = brq_idu_pkg::BRQ_XLEN,
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 3,
   parameter int CTRL_W  = 16,
   parameter int CNT_W   = 16
);
   logic                      in_valid;
   logic                      in_ready;
   logic [XLEN-1:0]           in_pc;
   logic [XLEN-1:0]           in_imm;
   logic [REG_AW-1:0]         in_rs1;
   logic [REG_AW-1:0]         in_rs2;
   logic                      in_rs1_used;
   logic                      in_rs2_used;
   logic [XLEN-1:0]           in_rs1_data;
   logic [XLEN-1:0]           in_rs2_data;
   logic [REG_AW-1:0]         in_rd;
   logic                      in_rd_we;
   logic                      in_is_load;
   logic [CTRL_W-1:0]         in_ctrl;
   logic [NUM_FWD-1:0]        fwd_valid;
   logic [NUM_FWD-1:0]        fwd_data_ok;
   logic [NUM_FWD*REG_AW-1:0] fwd_rd;
   logic [NUM_FWD*XLEN-1:0]   fwd_data;
   logic                      flush;
   logic                      out_valid;
   logic                      out_ready;
   logic [XLEN-1:0]           out_pc;
   logic [XLEN-1:0]           out_imm;
   logic [XLEN-1:0]           out_op_a;
   logic [XLEN-1:0]           out_op_b;
   logic [REG_AW-1:0]         out_rd;
   logic                      out_rd_we;
   logic                      out_is_load;
   logic [CTRL_W-1:0]         out_ctrl;
   logic [CNT_W-1:0]          hz_stall_cnt;
   logic [CNT_W-1:0]          bp_stall_cnt;

   modport master (
      output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
             in_rs1_data, in_rs2_data, in_rd, in_rd_we, in_is_load, in_ctrl,
             fwd_valid, fwd_data_ok, fwd_rd, fwd_data, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_imm, out_op_a, out_op_b, out_rd,
             out_rd_we, out_is_load, out_ctrl, hz_stall_cnt, bp_stall_cnt
   );

   modport slave (
      input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
             in_rs1_data, in_rs2_data, in_rd, in_rd_we, in_is_load, in_ctrl,
             fwd_valid, fwd_data_ok, fwd_rd, fwd_data, flush, out_ready,
      output in_ready, out_valid, out_pc, out_imm, out_op_a, out_op_b, out_rd,
             out_rd_we, out_is_load, out_ctrl, hz_stall_cnt, bp_stall_cnt
   );
endinterface

// File: rtl/brq_fwd_resolve.sv
// brq_fwd_resolve: youngest-match forwarding lookup for one source operand
// BRQ_IDU_FWD_EN selects forwarded data; without it every live match is a hazard.
module brq_fwd_resolve
   import brq_idu_pkg::*;
#(
   parameter int XLEN    = BRQ_XLEN,
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 3
) (
   input  logic [REG_AW-1:0]         i_rs,
   input  logic                      i_used,
   input  logic [XLEN-1:0]           i_rf_data,
   input  logic [NUM_FWD-1:0]        i_fwd_valid,
   input  logic [NUM_FWD-1:0]        i_fwd_data_ok,
   input  logic [NUM_FWD*REG_AW-1:0] i_fwd_rd,
   input  logic [NUM_FWD*XLEN-1:0]   i_fwd_data,
   output src_res_t                  o_res
);
   logic            w_match;
   logic            w_ok;
   logic            w_hit;
   logic [XLEN-1:0] w_fwd;

   // walk oldest to youngest so the lowest matching index is the one left standing
   always_comb begin
      w_match = 1'b0;
      w_ok    = 1'b0;
      w_fwd   = '0;
      for (int i = NUM_FWD - 1; i >= 0; i--)
         if (i_fwd_valid[i] && i_fwd_rd[i*REG_AW +: REG_AW] == i_rs) begin
            w_match = 1'b1;
            w_ok    = i_fwd_data_ok[i];
            w_fwd   = i_fwd_data[i*XLEN +: XLEN];
         end
   end

   assign w_hit = w_match & i_used & (i_rs != '0);

`ifdef BRQ_IDU_FWD_EN
   assign o_res = '{hit: w_hit, hazard: w_hit & ~w_ok, data: BRQ_XLEN'(w_hit ? w_fwd : i_rf_data)};
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{w_ok, w_fwd};
   assign o_res = '{hit: w_hit, hazard: w_hit, data: BRQ_XLEN'(i_rf_data)};
`endif
endmodule

// File: rtl/brq_idu_stage.sv
// brq_idu_stage: decode-to-execute stage with N-port forwarding, RAW stall and ID/EX register
// BRQ_IDU_FWD_EN enables operand forwarding; without it a live producer match always stalls.
module brq_idu_stage
   import brq_idu_pkg::*;
#(
   parameter int XLEN    = BRQ_XLEN,
   parameter int REG_AW  = 5,
   parameter int NUM_FWD = 3,
   parameter int CTRL_W  = 16,
   parameter int CNT_W   = 16
) (
   input logic      brq_clk,
   input logic      brq_rst_n,
   brq_idu_if.slave bus
);
   src_res_t          w_rs1;
   src_res_t          w_rs2;
   idu_state_t        r_state;
   idu_state_t        w_state_nx;
   logic              w_hazard;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_hz_inc;
   logic              w_bp_inc;
   logic              r_valid;
   logic              r_rd_we;
   logic              r_is_load;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_imm;
   logic [XLEN-1:0]   r_op_a;
   logic [XLEN-1:0]   r_op_b;
   logic [REG_AW-1:0] r_rd;
   logic [CTRL_W-1:0] r_ctrl;
   logic [CNT_W-1:0]  r_hz_cnt;
   logic [CNT_W-1:0]  r_bp_cnt;

   brq_fwd_resolve #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rs1 (
      .i_rs          (bus.in_rs1),
      .i_used        (bus.in_rs1_used),
      .i_rf_data     (bus.in_rs1_data),
      .i_fwd_valid   (bus.fwd_valid),
      .i_fwd_data_ok (bus.fwd_data_ok),
      .i_fwd_rd      (bus.fwd_rd),
      .i_fwd_data    (bus.fwd_data),
      .o_res         (w_rs1)
   );

   brq_fwd_resolve #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rs2 (
      .i_rs          (bus.in_rs2),
      .i_used        (bus.in_rs2_used),
      .i_rf_data     (bus.in_rs2_data),
      .i_fwd_valid   (bus.fwd_valid),
      .i_fwd_data_ok (bus.fwd_data_ok),
      .i_fwd_rd      (bus.fwd_rd),
      .i_fwd_data    (bus.fwd_data),
      .o_res         (w_rs2)
   );

   assign w_hazard   = bus.in_valid & ((w_rs1.hit & w_rs1.hazard) | (w_rs2.hit & w_rs2.hazard));
   assign w_in_ready = ~bus.flush & ~w_hazard & (~r_valid | bus.out_ready);
   assign w_accept   = bus.in_valid & w_in_ready;

   always_ff @(posedge brq_clk or negedge brq_rst_n)
      if (!brq_rst_n) r_state <= RUN;
      else r_state <= w_state_nx;

   always_comb begin
      w_state_nx = r_state;
      if (bus.flush) w_state_nx = RUN;
      else if (r_valid && !bus.out_ready && bus.in_valid && !w_hazard) w_state_nx = BP_STALL;
      else if (r_state == BP_STALL) w_state_nx = bus.out_ready ? RUN : BP_STALL;
      else w_state_nx = w_hazard ? HZ_STALL : RUN;
   end

   // a hazard cycle counts while stalled or on the cycle that enters the stall
   always_comb begin
      w_hz_inc = w_hazard & ((r_state == HZ_STALL) | (w_state_nx == HZ_STALL));
      w_bp_inc = r_valid & ~bus.out_ready;
   end

   always_ff @(posedge brq_clk or negedge brq_rst_n)
      if (!brq_rst_n) begin
         r_hz_cnt <= '0;
         r_bp_cnt <= '0;
      end else begin
         r_hz_cnt <= r_hz_cnt + CNT_W'(w_hz_inc & ~&r_hz_cnt);
         r_bp_cnt <= r_bp_cnt + CNT_W'(w_bp_inc & ~&r_bp_cnt);
      end

   always_ff @(posedge brq_clk or negedge brq_rst_n)
      if (!brq_rst_n) begin
         r_valid   <= 1'b0;
         r_rd_we   <= 1'b0;
         r_is_load <= 1'b0;
         r_pc      <= '0;
         r_imm     <= '0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_rd      <= '0;
         r_ctrl    <= '0;
      end else if (bus.flush) begin
         r_valid   <= 1'b0;
         r_rd_we   <= 1'b0;
         r_is_load <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_rd_we   <= bus.in_rd_we;
         r_is_load <= bus.in_is_load;
         r_pc      <= bus.in_pc;
         r_imm     <= bus.in_imm;
         r_op_a    <= XLEN'(w_rs1.data);
         r_op_b    <= XLEN'(w_rs2.data);
         r_rd      <= bus.in_rd;
         r_ctrl    <= bus.in_ctrl;
      end else if (bus.out_ready) begin
         r_valid   <= 1'b0;
         r_rd_we   <= 1'b0;
         r_is_load <= 1'b0;
      end

   assign bus.in_ready     = w_in_ready;
   assign bus.out_valid    = r_valid;
   assign bus.out_pc       = r_pc;
   assign bus.out_imm      = r_imm;
   assign bus.out_op_a     = r_op_a;
   assign bus.out_op_b     = r_op_b;
   assign bus.out_rd       = r_rd;
   assign bus.out_rd_we    = r_rd_we;
   assign bus.out_is_load  = r_is_load;
   assign bus.out_ctrl     = r_ctrl;
   assign bus.hz_stall_cnt = r_hz_cnt;
   assign bus.bp_stall_cnt = r_bp_cnt;
endmodule

// File: tb/tb_brq_idu_stage.sv
// tb_brq_idu_stage: directed checks of forwarding, hazards, backpressure, flush and reset
module tb_brq_idu_stage;
   localparam int XLEN = 32, REG_AW = 5, NUM_FWD = 3, CTRL_W = 16, CNT_W = 3;

   logic brq_clk = 1'b0;
   logic brq_rst_n = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   brq_idu_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

   brq_idu_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .brq_clk   (brq_clk),
      .brq_rst_n (brq_rst_n),
      .bus       (bus)
   );

   always #5 brq_clk = ~brq_clk;

   task automatic tick();
      @(posedge brq_clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.in_pc = 0; bus.in_imm = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
      bus.in_rs1_used = 0; bus.in_rs2_used = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0;
      bus.in_rd = 0; bus.in_rd_we = 0; bus.in_is_load = 0; bus.in_ctrl = 0;
      bus.fwd_valid = 0; bus.fwd_data_ok = 0; bus.fwd_rd = 0; bus.fwd_data = 0;
      bus.flush = 0; bus.out_ready = 1;
   endtask

   task automatic do_reset();
      idle();
      brq_rst_n = 0;
      #2;
      brq_rst_n = 1;
      tick();
   endtask

   task automatic ins(input logic [31:0] pc, input logic [4:0] rs1, input logic u1, input logic [31:0] d1,
                      input logic [4:0] rs2, input logic u2, input logic [31:0] d2,
                      input logic [4:0] rd, input logic we, input logic ld);
      bus.in_valid = 1; bus.in_pc = pc; bus.in_imm = pc + 32'h10; bus.in_ctrl = pc[15:0] ^ 16'h00ff;
      bus.in_rs1 = rs1; bus.in_rs1_used = u1; bus.in_rs1_data = d1;
      bus.in_rs2 = rs2; bus.in_rs2_used = u2; bus.in_rs2_data = d2;
      bus.in_rd = rd; bus.in_rd_we = we; bus.in_is_load = ld;
   endtask

   task automatic fwd(input int p, input logic v, input logic ok, input logic [4:0] rd, input logic [31:0] d);
      bus.fwd_valid[p] = v;
      bus.fwd_data_ok[p] = ok;
      bus.fwd_rd[p*REG_AW +: REG_AW] = rd;
      bus.fwd_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic test_reset();
      idle();
      #1 brq_rst_n = 0;
      #1;
      n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", bus.out_valid); else n_pass++;
      n_total++; if (bus.out_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", bus.out_pc); else n_pass++;
      n_total++; if (bus.hz_stall_cnt !== 3'd0 || bus.bp_stall_cnt !== 3'd0)
         $display("FAIL rst_cnt got hz=%0d bp=%0d want 0/0", bus.hz_stall_cnt, bus.bp_stall_cnt); else n_pass++;
      brq_rst_n = 1;
      ins(32'h40, 5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd3, 1, 0);
      #1;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_first_ready got %0b want 1", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40)
         $display("FAIL rst_first_accept got v=%0b pc=%h want 1/00000040", bus.out_valid, bus.out_pc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      ins(32'h100, 5'd1, 1, 32'h11, 5'd2, 1, 32'h22, 5'd5, 1, 0);
      tick();
      n_total++; if (bus.out_op_a !== 32'h11 || bus.out_op_b !== 32'h22)
         $display("FAIL b2b_rf_ops got %h %h want 00000011 00000022", bus.out_op_a, bus.out_op_b); else n_pass++;
      n_total++; if (bus.out_imm !== 32'h110 || bus.out_ctrl !== 16'h01ff || bus.out_rd !== 5'd5 || bus.out_rd_we !== 1'b1)
         $display("FAIL b2b_fields got imm=%h ctrl=%h rd=%0d we=%0b", bus.out_imm, bus.out_ctrl, bus.out_rd, bus.out_rd_we); else n_pass++;
      fwd(0, 1, 1, 5'd5, 32'h1234);
      ins(32'h104, 5'd5, 1, 32'hdead, 5'd6, 1, 32'h66, 5'd8, 1, 0);
      #1;
`ifdef BRQ_IDU_FWD_EN
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready got %0b want 1", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_op_a !== 32'h1234 || bus.out_pc !== 32'h104)
         $display("FAIL b2b_fwd got v=%0b a=%h pc=%h want 1/00001234/00000104", bus.out_valid, bus.out_op_a, bus.out_pc); else n_pass++;
`else
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_nofwd_stall got %0b want 0", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_valid !== 1'b0 || bus.hz_stall_cnt !== 3'd1)
         $display("FAIL b2b_bubble got v=%0b hz=%0d want 0/1", bus.out_valid, bus.hz_stall_cnt); else n_pass++;
      fwd(0, 0, 1, 5'd5, 32'h1234);
      #1;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_release got %0b want 1", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_op_a !== 32'hdead || bus.out_pc !== 32'h104)
         $display("FAIL b2b_rf got v=%0b a=%h pc=%h want 1/0000dead/00000104", bus.out_valid, bus.out_op_a, bus.out_pc); else n_pass++;
`endif
      idle();
   endtask

   task automatic test_load_use();
      do_reset();
      fwd(0, 1, 0, 5'd7, 32'h5555);
      ins(32'h300, 5'd0, 0, 32'h0, 5'd7, 1, 32'h77, 5'd9, 1, 0);
      #1;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL lu_stall1 got %0b want 0", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL lu_stall2 got %0b want 0", bus.in_ready); else n_pass++;
      tick();
`ifdef BRQ_IDU_FWD_EN
      fwd(0, 1, 1, 5'd7, 32'h5555);
`else
      fwd(0, 0, 0, 5'd7, 32'h5555);
`endif
      #1;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL lu_release got %0b want 1", bus.in_ready); else n_pass++;
      tick();
`ifdef BRQ_IDU_FWD_EN
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_op_b !== 32'h5555)
         $display("FAIL lu_op_b got v=%0b b=%h want 1/00005555", bus.out_valid, bus.out_op_b); else n_pass++;
`else
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_op_b !== 32'h77)
         $display("FAIL lu_op_b got v=%0b b=%h want 1/00000077", bus.out_valid, bus.out_op_b); else n_pass++;
`endif
      n_total++; if (bus.hz_stall_cnt !== 3'd2) $display("FAIL lu_hz_cnt got %0d want 2", bus.hz_stall_cnt); else n_pass++;
      idle();
   endtask

   task automatic test_priority();
      do_reset();
      fwd(0, 1, 1, 5'd3, 32'hA);
      fwd(1, 1, 1, 5'd9, 32'hC);
      fwd(2, 1, 1, 5'd3, 32'hB);
      ins(32'h400, 5'd3, 1, 32'h33, 5'd4, 1, 32'h44, 5'd1, 1, 0);
      #1;
`ifdef BRQ_IDU_FWD_EN
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL prio_ready got %0b want 1", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_op_a !== 32'hA) $display("FAIL prio_youngest got %h want 0000000a", bus.out_op_a); else n_pass++;
      fwd(0, 0, 1, 5'd3, 32'hA);
      ins(32'h404, 5'd3, 1, 32'h33, 5'd4, 1, 32'h44, 5'd1, 1, 0);
      tick();
      n_total++; if (bus.out_op_a !== 32'hB || bus.out_pc !== 32'h404)
         $display("FAIL prio_oldest got a=%h pc=%h want 0000000b/00000404", bus.out_op_a, bus.out_pc); else n_pass++;
`else
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL prio_stall got %0b want 0", bus.in_ready); else n_pass++;
      fwd(0, 0, 1, 5'd3, 32'hA);
      #1;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL prio_port2_stall got %0b want 0", bus.in_ready); else n_pass++;
      tick();
`endif
      idle();
      fwd(0, 1, 1, 5'd0, 32'hA);
      fwd(2, 1, 0, 5'd3, 32'hB);
      ins(32'h408, 5'd0, 1, 32'h99, 5'd3, 0, 32'h55, 5'd2, 1, 0);
      #1;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL x0_unused_ready got %0b want 1", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_op_a !== 32'h99 || bus.out_op_b !== 32'h55)
         $display("FAIL x0_unused_ops got %h %h want 00000099 00000055", bus.out_op_a, bus.out_op_b); else n_pass++;
      idle();
   endtask

   task automatic test_backpressure();
      do_reset();
      ins(32'h200, 5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd2, 1, 0);
      tick();
      bus.out_ready = 0;
      ins(32'h204, 5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd3, 1, 0);
      #1;
      for (int k = 0; k < 4; k++) begin
         n_total++; if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h200 || bus.out_valid !== 1'b1)
            $display("FAIL bp_hold%0d got rdy=%0b v=%0b pc=%h want 0/1/00000200", k, bus.in_ready, bus.out_valid, bus.out_pc); else n_pass++;
         tick();
      end
      n_total++; if (bus.bp_stall_cnt !== 3'd4) $display("FAIL bp_cnt4 got %0d want 4", bus.bp_stall_cnt); else n_pass++;
      repeat (4) tick();
      n_total++; if (bus.bp_stall_cnt !== 3'd7) $display("FAIL bp_saturate got %0d want 7", bus.bp_stall_cnt); else n_pass++;
      bus.out_ready = 1;
      #1;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release got %0b want 1", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_pc !== 32'h204 || bus.bp_stall_cnt !== 3'd7 || bus.hz_stall_cnt !== 3'd0)
         $display("FAIL bp_after got pc=%h bp=%0d hz=%0d want 00000204/7/0", bus.out_pc, bus.bp_stall_cnt, bus.hz_stall_cnt); else n_pass++;
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      ins(32'h500, 5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd3, 1, 1);
      tick();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_is_load !== 1'b1)
         $display("FAIL fl_pre got v=%0b ld=%0b want 1/1", bus.out_valid, bus.out_is_load); else n_pass++;
      ins(32'h504, 5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd4, 1, 0);
      bus.flush = 1;
      bus.out_ready = 0;
      #1;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL fl_ready got %0b want 0", bus.in_ready); else n_pass++;
      tick();
      bus.flush = 0;
      n_total++; if (bus.out_valid !== 1'b0 || bus.out_rd_we !== 1'b0 || bus.out_is_load !== 1'b0)
         $display("FAIL fl_kill got v=%0b we=%0b ld=%0b want 0/0/0", bus.out_valid, bus.out_rd_we, bus.out_is_load); else n_pass++;
      n_total++; if (bus.bp_stall_cnt !== 3'd1) $display("FAIL fl_cnt_kept got %0d want 1", bus.bp_stall_cnt); else n_pass++;
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      ins(32'h600, 5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd4, 1, 0);
      tick();
      bus.out_ready = 0;
      fwd(0, 1, 0, 5'd7, 32'h0);
      ins(32'h604, 5'd7, 1, 32'h1, 5'd2, 1, 32'h2, 5'd5, 1, 0);
      tick();
      tick();
      n_total++; if (bus.hz_stall_cnt !== 3'd2 || bus.bp_stall_cnt !== 3'd2)
         $display("FAIL mid_cnt got hz=%0d bp=%0d want 2/2", bus.hz_stall_cnt, bus.bp_stall_cnt); else n_pass++;
      #1 brq_rst_n = 0;
      #1;
      n_total++; if (bus.out_valid !== 1'b0 || bus.out_rd_we !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_op_a !== 32'h0)
         $display("FAIL mid_rst_out got v=%0b we=%0b pc=%h a=%h want zeros", bus.out_valid, bus.out_rd_we, bus.out_pc, bus.out_op_a); else n_pass++;
      n_total++; if (bus.hz_stall_cnt !== 3'd0 || bus.bp_stall_cnt !== 3'd0)
         $display("FAIL mid_rst_cnt got hz=%0d bp=%0d want 0/0", bus.hz_stall_cnt, bus.bp_stall_cnt); else n_pass++;
      idle();
      brq_rst_n = 1;
      ins(32'h700, 5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd6, 1, 0);
      #1;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_first_ready got %0b want 1", bus.in_ready); else n_pass++;
      tick();
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h700)
         $display("FAIL mid_first_accept got v=%0b pc=%h want 1/00000700", bus.out_valid, bus.out_pc); else n_pass++;
      idle();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load_use();
      test_priority();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
